// File: rtl/ds_rd_port_if.sv
// ---------------------------------------------------------------------------
// ds_rd_port_if
//
// Purpose:
//   Groups the client-side request/word-stream signals and the
//   memory-controller read channel of one ddrScheduler read port.
//
// Modports:
//   slave  - the read port itself (ds_rd_port): it receives client
//            requests and controller responses, and drives grants, words
//            and burst commands.
//   master - the surroundings (client plus memory controller), which is
//            the mirror image of slave.
//
// Signals:
//   rdDS_req / rdDS_Vaddr / rdDS_granted       client request handshake
//   rdDS_data18bit / rdDS_data18bit_vld        unpacked 18-bit word stream
//   mem_rd_cmd_vld / _rdy / _addr / _len       burst read command
//   mem_rd_data / _vld / _rdy                  returned 144-bit beats
// ---------------------------------------------------------------------------
interface ds_rd_port_if #(
    parameter int WIDTH_rdDS_Vaddr = 22,
    parameter int WIDTH_MEM_ADDR   = 28
);
    logic                        rdDS_req;
    logic [WIDTH_rdDS_Vaddr-1:0] rdDS_Vaddr;
    logic                        rdDS_granted;
    logic [17:0]                 rdDS_data18bit;
    logic                        rdDS_data18bit_vld;

    logic                        mem_rd_cmd_vld;
    logic                        mem_rd_cmd_rdy;
    logic [WIDTH_MEM_ADDR-1:0]   mem_rd_addr;
    logic [7:0]                  mem_rd_len;
    logic [143:0]                mem_rd_data;
    logic                        mem_rd_data_vld;
    logic                        mem_rd_data_rdy;

    modport slave (
        input  rdDS_req,
        input  rdDS_Vaddr,
        output rdDS_granted,
        output rdDS_data18bit,
        output rdDS_data18bit_vld,
        output mem_rd_cmd_vld,
        input  mem_rd_cmd_rdy,
        output mem_rd_addr,
        output mem_rd_len,
        input  mem_rd_data,
        input  mem_rd_data_vld,
        output mem_rd_data_rdy
    );

    modport master (
        output rdDS_req,
        output rdDS_Vaddr,
        input  rdDS_granted,
        input  rdDS_data18bit,
        input  rdDS_data18bit_vld,
        input  mem_rd_cmd_vld,
        output mem_rd_cmd_rdy,
        input  mem_rd_addr,
        input  mem_rd_len,
        output mem_rd_data,
        output mem_rd_data_vld,
        input  mem_rd_data_rdy
    );
endinterface

// File: rtl/ds_rd_port.sv
// ---------------------------------------------------------------------------
// ds_rd_port
//
// Purpose:
//   Read-side responder of the ddrScheduler client protocol. Serves one
//   line-buffer client: grants its request, issues a single burst read of
//   BATCH_WORDS/8 beats to the memory controller, buffers the returned
//   144-bit beats in a small FIFO and unpacks them into a gap-free stream
//   of 18-bit words (word [17:0] of each beat first).
//
// Ports:
//   clk           sole clock
//   reset         synchronous, active-low
//   bus           ds_rd_port_if.slave: client request/word stream and
//                 memory-controller read channel
//   stat_batches  completed-batch counter (only with DS_RD_STATS_EN)
//
// Configuration macro:
//   DS_RD_STATS_EN - when defined, adds the stat_batches port and its
//                    16-bit wrapping counter of completed batches.
// ---------------------------------------------------------------------------
module ds_rd_port #(
    parameter int          BATCH_WORDS      = 224,
    parameter int          WIDTH_rdDS_Vaddr = 22,
    parameter int unsigned BASE_BEAT        = 0,
    parameter int          WIDTH_MEM_ADDR   = 28,
    parameter int          FIFO_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        reset,
    ds_rd_port_if.slave bus
`ifdef DS_RD_STATS_EN
    ,
    output logic [15:0] stat_batches
`endif
);

    localparam int BEATS  = BATCH_WORDS / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(BATCH_WORDS);

    localparam logic [7:0]        LEN_C     = 8'(BEATS - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BATCH_WORDS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        CMD    = 2'd2,
        STREAM = 2'd3
    } state_t;

    // FSM and command registers
    state_t                    state_q, state_d;
    logic [WIDTH_MEM_ADDR-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic                      granted;
    logic                      cmd_vld;
    logic                      batch_done;

    // Beat FIFO
    logic [7:0][17:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [7:0][17:0]          fifo_head;
    logic                      fifo_empty;
    logic                      data_rdy;
    logic                      push;
    logic                      pop;

    // Unpacker shifter and registered word output
    logic [7:0][17:0]          sh_words_q, sh_words_d;
    logic [2:0]                sh_idx_q, sh_idx_d;
    logic                      sh_vld_q, sh_vld_d;
    logic                      emit;
    logic [17:0]               emit_word;
    logic [17:0]               out_data_q, out_data_d;
    logic                      out_vld_q, out_vld_d;

    // Word counter for the current batch
    logic [WCNT_W-1:0]         word_cnt_q, word_cnt_d;

    // The low three address bits select a word inside a beat; clients are
    // beat-aligned, so they carry no information here.
    logic                      unused_vaddr_lsbs;
    assign unused_vaddr_lsbs = ^bus.rdDS_Vaddr[2:0];

    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign fifo_empty = (fifo_cnt_q == '0);
    assign data_rdy   = (fifo_cnt_q < DEPTH_C);
    assign push       = bus.mem_rd_data_vld && data_rdy;

    // Unpacker. An empty shifter takes the FIFO head and emits its word 0
    // straight into the output register in the same cycle, which keeps the
    // beat-to-first-word latency at two registers. While the shifter is
    // emitting word 7 it reloads from the FIFO head, so back-to-back beats
    // produce one word every cycle without a bubble.
    always_comb begin
        pop        = 1'b0;
        emit       = 1'b0;
        emit_word  = out_data_q;
        sh_words_d = sh_words_q;
        sh_idx_d   = sh_idx_q;
        sh_vld_d   = sh_vld_q;

        if (sh_vld_q) begin
            emit      = 1'b1;
            emit_word = sh_words_q[sh_idx_q];
            if (sh_idx_q == 3'd7) begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sh_words_d = fifo_head;
                    sh_idx_d   = 3'd0;
                    sh_vld_d   = 1'b1;
                end else begin
                    sh_vld_d   = 1'b0;
                end
            end else begin
                sh_idx_d = sh_idx_q + 3'd1;
            end
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            emit       = 1'b1;
            emit_word  = fifo_head[0];
            sh_words_d = fifo_head;
            sh_idx_d   = 3'd1;
            sh_vld_d   = 1'b1;
        end

        out_vld_d  = emit;
        out_data_d = emit ? emit_word : out_data_q;
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Request FSM. The burst address is latched on the edge that accepts
    // the request; a request still held high outside IDLE is ignored.
    // The batch ends on the edge that emits its last word.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        granted    = 1'b0;
        cmd_vld    = 1'b0;
        batch_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rdDS_req) begin
                    state_d = GRANT;
                    addr_d  = WIDTH_MEM_ADDR'(BASE_BEAT)
                            + WIDTH_MEM_ADDR'(bus.rdDS_Vaddr[WIDTH_rdDS_Vaddr-1:3]);
                    len_d   = LEN_C;
                end
            end
            GRANT: begin
                granted = 1'b1;
                state_d = CMD;
            end
            CMD: begin
                cmd_vld = 1'b1;
                if (bus.mem_rd_cmd_rdy) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (emit && (word_cnt_q == LAST_WORD)) begin
                    state_d    = IDLE;
                    batch_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Words of the batch may already flow while the command is still being
    // handshaked (early beats count toward the batch), so the counter runs
    // in CMD as well as STREAM and clears when the batch completes.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (batch_done) begin
            word_cnt_d = '0;
        end else if (emit && ((state_q == CMD) || (state_q == STREAM))) begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
        end
    end

    // Control state register; every field returns to zero on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            sh_words_q <= '0;
            sh_idx_q   <= '0;
            sh_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            sh_words_q <= sh_words_d;
            sh_idx_q   <= sh_idx_d;
            sh_vld_q   <= sh_vld_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_rd_data;
        end
    end

`ifdef DS_RD_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Completed-batch counter; wraps naturally at 16 bits.
    always_comb begin
        stat_d = stat_q;
        if (batch_done) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_batches = stat_q;
`endif

    assign bus.rdDS_granted       = granted;
    assign bus.rdDS_data18bit     = out_data_q;
    assign bus.rdDS_data18bit_vld = out_vld_q;
    assign bus.mem_rd_cmd_vld     = cmd_vld;
    assign bus.mem_rd_addr        = addr_q;
    assign bus.mem_rd_len         = len_q;
    assign bus.mem_rd_data_rdy    = data_rdy;

endmodule

// File: tb/tb_ds_rd_port.sv
// ---------------------------------------------------------------------------
// tb_ds_rd_port
//
// Self-checking bench for ds_rd_port. A table of batch scenarios (address,
// command stall, beat spacing, request hold) is run in a loop; for each
// one a client process, a controller command process and a beat process
// run in parallel. Every accepted beat pushes its eight expected words to
// a scoreboard queue that a negedge monitor pops on each valid word.
// A hand-written sequence resets the block in the middle of a stream and
// then checks that a following batch runs normally.
//
// Cycle bookkeeping: cyc counts rising edges, so a value observed with
// cyc == n was registered on edge n (the cycle after edge n).
// ---------------------------------------------------------------------------
module tb_ds_rd_port;

    localparam int          BATCH_WORDS = 224;
    localparam int          BEATS       = BATCH_WORDS / 8;
    localparam int          WV          = 22;
    localparam int          WMA         = 28;
    localparam int unsigned BASE        = 32'h40;
    localparam int          FD          = 8;

    typedef struct {
        string       name;
        logic [21:0] vaddr;
        int          cmdStall;
        int          beatGap;
        int          reqHold;
        logic [17:0] wordBase;
        logic [27:0] expAddr;
        int          expGaps;
        bit          expRdyDrop;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ds_rd_port_if #(.WIDTH_rdDS_Vaddr(WV), .WIDTH_MEM_ADDR(WMA)) bus ();

`ifdef DS_RD_STATS_EN
    logic [15:0] stat_batches;
`endif

    ds_rd_port #(
        .BATCH_WORDS      (BATCH_WORDS),
        .WIDTH_rdDS_Vaddr (WV),
        .BASE_BEAT        (BASE),
        .WIDTH_MEM_ADDR   (WMA),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef DS_RD_STATS_EN
        ,
        .stat_batches (stat_batches)
`endif
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          monitorOn  = 1'b0;
    bit          abortFlag  = 1'b0;
    logic [17:0] expQ[$];
    logic [17:0] lastData   = '0;
    logic [27:0] expAddrRef = '0;
    int wordsThisBatch, gapCycles, grantsThisBatch, cmdAccepts;
    int beatsAccepted, rdyLowCycles, firstVldCyc, firstAcceptEdge, reqEdge;
    int batchesDone = 0;

    // Count rising edges.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [143:0] makeBeat(input logic [17:0] base, input int k);
        logic [143:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j*18 +: 18] = base + 18'(8 * k + j);
        end
        return b;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (bus.rdDS_granted) grantsThisBatch++;
                if (bus.mem_rd_cmd_vld) begin
                    checkOutput("cmd_addr", bus.mem_rd_addr, expAddrRef);
                    if (bus.mem_rd_cmd_rdy) cmdAccepts++;
                end
                if (!bus.mem_rd_data_rdy) rdyLowCycles++;
                if (bus.rdDS_data18bit_vld) begin
                    checkOutput("sb_word_available", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        checkOutput($sformatf("word%0d", wordsThisBatch),
                                    bus.rdDS_data18bit, expQ.pop_front());
                    end
                    if (wordsThisBatch == 0) firstVldCyc = cyc;
                    wordsThisBatch++;
                end else begin
                    if (wordsThisBatch > 0 && wordsThisBatch < BATCH_WORDS) gapCycles++;
                    checkOutput("data_hold", bus.rdDS_data18bit, lastData);
                end
            end
            lastData = bus.rdDS_data18bit;
        end
    end

    // Client: raise the request, expect the grant on the cycle after the
    // sampling edge, then keep req up for reqHold extra cycles.
    task automatic applyStimulus(input vec_t v);
        bit got = 1'b0;
        bus.rdDS_Vaddr = v.vaddr;
        bus.rdDS_req   = 1'b1;
        reqEdge        = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rdDS_granted) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({v.name, "_grant_seen"}, got, 1);
        if (got) checkOutput({v.name, "_grant_cycle"}, cyc, reqEdge);
        repeat (1 + v.reqHold) begin
            @(posedge clk);
            #1;
        end
        bus.rdDS_req = 1'b0;
    endtask

    // Controller command side: optional stall of cmdStall cycles.
    task automatic cmdResponder(input vec_t v);
        bit got = 1'b0;
        bus.mem_rd_cmd_rdy = (v.cmdStall == 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rd_cmd_vld) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({v.name, "_cmd_seen"}, got, 1);
        if (got) begin
            checkOutput({v.name, "_cmd_cycle"}, cyc, reqEdge + 1);
            checkOutput({v.name, "_cmd_len"}, bus.mem_rd_len, BEATS - 1);
        end
        repeat (v.cmdStall) begin
            @(posedge clk);
            #1;
        end
        bus.mem_rd_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rd_cmd_rdy = 1'b0;
    endtask

    // Controller data side: BEATS beats, beatGap idle cycles between them.
    task automatic beatSender(input vec_t v);
        bit ok = 1'b0;
        bus.mem_rd_data_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (cmdAccepts > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({v.name, "_cmd_accepted"}, ok, 1);
        for (int k = 0; k < BEATS && ok && !abortFlag; k++) begin
            int w = 0;
            bus.mem_rd_data_vld = 1'b1;
            bus.mem_rd_data     = makeBeat(v.wordBase, k);
            while (!bus.mem_rd_data_rdy && !abortFlag && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (abortFlag) break;
            if (!bus.mem_rd_data_rdy) begin
                checkOutput({v.name, "_beat_rdy_timeout"}, bus.mem_rd_data_rdy, 1);
                break;
            end
            for (int j = 0; j < 8; j++) expQ.push_back(v.wordBase + 18'(8 * k + j));
            beatsAccepted++;
            if (firstAcceptEdge < 0) firstAcceptEdge = cyc + 1;
            @(posedge clk);
            #1;
            if (v.beatGap > 0) begin
                bus.mem_rd_data_vld = 1'b0;
                repeat (v.beatGap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.mem_rd_data_vld = 1'b0;
    endtask

    task automatic waitWords();
        for (int i = 0; i < 1500 && wordsThisBatch < BATCH_WORDS && !abortFlag; i++) begin
            @(negedge clk);
        end
    endtask

    // Reset in the middle of the stream once abortAt words have been seen.
    task automatic resetWatcher(input int abortAt);
        if (abortAt > 0) begin
            for (int i = 0; i < 1000 && wordsThisBatch < abortAt; i++) begin
                @(negedge clk);
                #1;
            end
            checkOutput("midreset_reached_word", wordsThisBatch, abortAt);
            monitorOn = 1'b0;
            abortFlag = 1'b1;
            reset     = 1'b0;
            @(negedge clk);
            checkOutput("midreset_granted", bus.rdDS_granted, 0);
            checkOutput("midreset_vld", bus.rdDS_data18bit_vld, 0);
            checkOutput("midreset_data", bus.rdDS_data18bit, 0);
            checkOutput("midreset_cmd_vld", bus.mem_rd_cmd_vld, 0);
            checkOutput("midreset_addr", bus.mem_rd_addr, 0);
            checkOutput("midreset_len", bus.mem_rd_len, 0);
`ifdef DS_RD_STATS_EN
            checkOutput("midreset_stat", stat_batches, 0);
`endif
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            reset = 1'b1;
            expQ.delete();
            batchesDone = 0;
        end
    endtask

    task automatic runBatch(input vec_t v, input int abortAt);
        wordsThisBatch  = 0;
        gapCycles       = 0;
        grantsThisBatch = 0;
        cmdAccepts      = 0;
        beatsAccepted   = 0;
        rdyLowCycles    = 0;
        firstVldCyc     = -1;
        firstAcceptEdge = -1;
        expQ.delete();
        expAddrRef = v.expAddr;
        abortFlag  = 1'b0;
        monitorOn  = 1'b1;
        @(posedge clk);
        #1;
        fork
            applyStimulus(v);
            cmdResponder(v);
            beatSender(v);
            resetWatcher(abortAt);
            waitWords();
        join
        if (!abortFlag) begin
            repeat (3) @(negedge clk);
            checkOutput({v.name, "_words"}, wordsThisBatch, BATCH_WORDS);
            checkOutput({v.name, "_gaps"}, gapCycles, v.expGaps);
            checkOutput({v.name, "_grants"}, grantsThisBatch, 1);
            checkOutput({v.name, "_cmd_accepts"}, cmdAccepts, 1);
            checkOutput({v.name, "_beats"}, beatsAccepted, BEATS);
            checkOutput({v.name, "_sb_empty"}, expQ.size(), 0);
            checkOutput({v.name, "_first_word_latency"}, firstVldCyc - firstAcceptEdge, 1);
            checkOutput({v.name, "_rdy_drop"}, rdyLowCycles > 0, v.expRdyDrop);
            checkOutput({v.name, "_idle_cmd_vld"}, bus.mem_rd_cmd_vld, 0);
            batchesDone++;
`ifdef DS_RD_STATS_EN
            checkOutput({v.name, "_stat"}, stat_batches, batchesDone);
`endif
        end
        monitorOn = 1'b0;
    endtask

    vec_t vecs[5];
    vec_t midVec;
    vec_t recVec;

    initial begin
        bus.rdDS_req        = 1'b0;
        bus.rdDS_Vaddr      = '0;
        bus.mem_rd_cmd_rdy  = 1'b0;
        bus.mem_rd_data     = '0;
        bus.mem_rd_data_vld = 1'b0;

        //          name        vaddr       stall gap hold wordBase   expAddr      gaps drop
        vecs[0] = '{"single",    22'h000100, 0,    0,  0,   18'h00000, 28'h0000060, 0,   1'b1};
        vecs[1] = '{"stall",     22'h0002A8, 5,    0,  0,   18'h01000, 28'h0000095, 0,   1'b1};
        vecs[2] = '{"sparse",    22'h000008, 0,    11, 0,   18'h02000, 28'h0000041, 108, 1'b0};
        vecs[3] = '{"reqhold",   22'h3FFFF8, 0,    0,  2,   18'h3FF80, 28'h008003F, 0,   1'b1};
        vecs[4] = '{"unaligned", 22'h000107, 2,    0,  0,   18'h05000, 28'h0000060, 0,   1'b1};
        midVec  = '{"midreset",  22'h000200, 0,    0,  0,   18'h03000, 28'h0000080, 0,   1'b1};
        recVec  = '{"recover",   22'h000040, 0,    0,  0,   18'h00020, 28'h0000048, 0,   1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_granted", bus.rdDS_granted, 0);
        checkOutput("reset_vld", bus.rdDS_data18bit_vld, 0);
        checkOutput("reset_data", bus.rdDS_data18bit, 0);
        checkOutput("reset_cmd_vld", bus.mem_rd_cmd_vld, 0);
        checkOutput("reset_addr", bus.mem_rd_addr, 0);
        checkOutput("reset_len", bus.mem_rd_len, 0);
`ifdef DS_RD_STATS_EN
        checkOutput("reset_stat", stat_batches, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            $display("[TB] scenario %s", vecs[i].name);
            runBatch(vecs[i], 0);
        end

        $display("[TB] scenario %s", midVec.name);
        runBatch(midVec, 101);

        $display("[TB] scenario %s", recVec.name);
        runBatch(recVec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
